// File: rtl/vid_phy_controller_gt_tx_tmdsclk_ctrl.sv
// Sequences TMDS-clock ratio changes for the GT TX pattern generator: disable, hold,
// swap ratio, settle, then re-enable once the transmitter reports ready.
module vid_phy_controller_gt_tx_tmdsclk_ctrl #(
    parameter int HOLD_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_WIDTH     = 8
) (
    input  logic       CLK_IN,
    input  logic       RESET_N_IN,
    input  logic       REQ_IN,
    input  logic [2:0] REQ_RATIO_IN,
    output logic       ACK_OUT,
    input  logic       TX_READY_IN,
    output logic       CTRL_EN_OUT,
    output logic [2:0] CTRL_RATIO_OUT,
    output logic       BUSY_OUT,
    output logic       DONE_OUT,
    output logic       ERR_OUT,
    output logic       LOST_OUT,
    output logic [2:0] STATE_DBG_OUT
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD     = 3'd1,
        S_SETTLE   = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [2:0]           pending_ratio, pending_ratio_n;
    logic [2:0]           ratio_n;
    logic                 ack_n, en_n, done_n, err_n, lost_n;
    logic                 accept;

    // Handshake: a request is taken when REQ_IN is high, the previous ACK has been
    // retired, and the sequencer is not in the middle of a disable/settle window.
    assign accept = REQ_IN && !ACK_OUT &&
                    (state == S_IDLE || state == S_WAIT_RDY || state == S_RUN);

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state          <= S_IDLE;
            cnt            <= '0;
            pending_ratio  <= 3'd0;
            ACK_OUT        <= 1'b0;
            CTRL_EN_OUT    <= 1'b0;
            CTRL_RATIO_OUT <= 3'd0;
            DONE_OUT       <= 1'b0;
            ERR_OUT        <= 1'b0;
            LOST_OUT       <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            pending_ratio  <= pending_ratio_n;
            ACK_OUT        <= ack_n;
            CTRL_EN_OUT    <= en_n;
            CTRL_RATIO_OUT <= ratio_n;
            DONE_OUT       <= done_n;
            ERR_OUT        <= err_n;
            LOST_OUT       <= lost_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        pending_ratio_n = pending_ratio;
        en_n            = CTRL_EN_OUT;
        ratio_n         = CTRL_RATIO_OUT;
        done_n          = 1'b0;
        err_n           = 1'b0;
        lost_n          = 1'b0;

        if (!REQ_IN)
            ack_n = 1'b0;
        else
            ack_n = ACK_OUT || accept;

        // An accepted request pre-empts any ready-driven transition on the same edge.
        if (accept) begin
            if (REQ_RATIO_IN <= 3'd5) begin
                pending_ratio_n = REQ_RATIO_IN;
                en_n            = 1'b0;
                cnt_n           = HOLD_LOAD;
                state_n         = S_HOLD;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == '0) begin
                        ratio_n = pending_ratio;
                        if (pending_ratio == 3'd0) begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            cnt_n   = SETTLE_LOAD;
                            state_n = S_SETTLE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0)
                        state_n = S_WAIT_RDY;
                    else
                        cnt_n = cnt - 1'b1;
                end
                S_WAIT_RDY: begin
                    if (TX_READY_IN) begin
                        en_n    = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    // Ratio is kept so the enable comes back by itself once ready returns.
                    if (!TX_READY_IN) begin
                        en_n    = 1'b0;
                        lost_n  = 1'b1;
                        state_n = S_WAIT_RDY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY_OUT      = (state == S_HOLD) || (state == S_SETTLE) || (state == S_WAIT_RDY);
    assign STATE_DBG_OUT = state;

endmodule
